i2s_rx_sample_source: RTL and testbench

//  Front-end feeding the FIR filter. Receives an I2S serial stream (SCLK, LRCLK, SDATA),

---
 rtl/i2s_rx_sample_source.sv | 226 ++++++++++++++++++++++
 tb/tb_i2s_rx_sample_source.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_sample_source.sv
// rtl/i2s_rx_sample_source.sv - I2S receiver front-end feeding a first-word-fall-through sample FIFO
//
// i2s_rx_fifo: first-word-fall-through sample queue
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, iv_din   write request and data
//   i_ready          consumer accepts the head entry this cycle
//   ov_dout, o_valid head entry, queue not empty
//   o_drop           pulse: a push was refused because the queue was full
//
// i2s_rx_sample_source: oversampled I2S deserialiser
//   i_clk, i_rst_n          system clock, asynchronous active-low reset
//   i_en                    capture enable
//   i_sclk/i_lrclk/i_sdata  asynchronous I2S inputs
//   i_ready, i_clr_err      consumer ready, clear sticky error flags
//   ov_dout, o_left         head sample and its channel tag (1 = left)
//   o_dout_valid            FIFO not empty
//   o_overflow, o_frame_err sticky error flags

module i2s_rx_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] iv_din,
  input  logic             i_ready,
  output logic [WIDTH-1:0] ov_dout,
  output logic             o_valid,
  output logic             o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign full    = (count == (AW+1)'(DEPTH));
  assign pop     = (count != '0) & i_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign wr_en   = i_push & (~full | pop);
  assign o_drop  = i_push & full & ~pop;
  assign o_valid = (count != '0);
  assign ov_dout = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= iv_din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module i2s_rx_sample_source #(
  parameter int DATA_WIDTH  = 24,
  parameter int CHANNEL_SEL = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_en,
  input  logic                         i_sclk,
  input  logic                         i_lrclk,
  input  logic                         i_sdata,
  input  logic                         i_ready,
  input  logic                         i_clr_err,
  output logic signed [DATA_WIDTH-1:0] ov_dout,
  output logic                         o_left,
  output logic                         o_dout_valid,
  output logic                         o_overflow,
  output logic                         o_frame_err
);
  localparam int             CW     = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]  LAST   = CW'(DATA_WIDTH - 1);
  localparam logic           SEL_LR = (CHANNEL_SEL == 1);

  typedef enum logic [1:0] {ST_HUNT, ST_SHIFT, ST_PAD} state_t;

  // sclk keeps a history stage for edge detection; lrclk/sdata are tapped at
  // the same sync2 depth so all three are sampled aligned at a rise.
  logic [2:0]            sclk_sr;
  logic [1:0]            lrclk_sr;
  logic [1:0]            sdata_sr;
  logic                  rise;
  logic                  lr;
  logic                  sd;
  logic                  lrclk_prev;
  logic                  primed;
  logic                  slot_start;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  chan_lr;
  logic                  done_lr;
  logic                  word_done;
  logic                  chan_ok;
  logic                  push;
  logic                  drop;
  logic [DATA_WIDTH:0]   head;

  assign rise = sclk_sr[1] & ~sclk_sr[2];
  assign lr   = lrclk_sr[1];
  assign sd   = sdata_sr[1];
  // primed suppresses a false slot start on the first rise after reset,
  // when lrclk_prev does not yet hold a real sample.
  assign slot_start = rise & primed & (lr != lrclk_prev);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sr  <= '0;
      lrclk_sr <= '0;
      sdata_sr <= '0;
    end else begin
      sclk_sr  <= {sclk_sr[1:0], i_sclk};
      lrclk_sr <= {lrclk_sr[0], i_lrclk};
      sdata_sr <= {sdata_sr[0], i_sdata};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_HUNT;
      cnt         <= '0;
      shreg       <= '0;
      chan_lr     <= 1'b0;
      done_lr     <= 1'b0;
      word_done   <= 1'b0;
      lrclk_prev  <= 1'b0;
      primed      <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (i_clr_err) o_frame_err <= 1'b0;
      if (rise) begin
        lrclk_prev <= lr;
        primed     <= 1'b1;
      end
      if (!i_en) begin
        state <= ST_HUNT;
      end else if (rise) begin
        case (state)
          ST_HUNT: begin
            if (slot_start) begin
              state   <= ST_SHIFT;
              cnt     <= '0;
              chan_lr <= lr;
            end
          end
          ST_SHIFT: begin
            if (slot_start && cnt != LAST) begin
              // Slot ended early: drop the partial word, start over on the new slot.
              o_frame_err <= 1'b1;
              cnt         <= '0;
              chan_lr     <= lr;
            end else begin
              shreg <= {shreg[DATA_WIDTH-2:0], sd};
              if (cnt == LAST) begin
                word_done <= 1'b1;
                done_lr   <= chan_lr;
                cnt       <= '0;
                // A slot exactly DATA_WIDTH long carries its LSB on the next
                // slot-start rise, so capture continues straight into it.
                if (slot_start) chan_lr <= lr;
                else            state   <= ST_PAD;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          ST_PAD: begin
            if (slot_start) begin
              state   <= ST_SHIFT;
              cnt     <= '0;
              chan_lr <= lr;
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

  assign chan_ok = (CHANNEL_SEL == 2) || (done_lr == SEL_LR);
  assign push    = word_done & i_en & chan_ok;

  i2s_rx_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .iv_din  ({~done_lr, shreg}),
    .i_ready (i_ready),
    .ov_dout (head),
    .o_valid (o_dout_valid),
    .o_drop  (drop)
  );

  assign ov_dout = head[DATA_WIDTH-1:0];
  assign o_left  = head[DATA_WIDTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       o_overflow <= 1'b0;
    else if (drop)      o_overflow <= 1'b1;
    else if (i_clr_err) o_overflow <= 1'b0;
  end
endmodule

// File: tb/tb_i2s_rx_sample_source.sv
// tb/tb_i2s_rx_sample_source.sv - scoreboard bench for i2s_rx_sample_source
module tb_i2s_rx_sample_source;
  localparam int W = 24;

  logic clk = 1'b0;
  logic rst_n, en, sclk, lrclk, sdata, clr_err;
  logic ready0, ready2;
  logic signed [W-1:0] dout0, dout2;
  logic left0, valid0, ovf0, ferr0;
  logic left2, valid2, ovf2, ferr2;

  always #5 clk = ~clk;

  i2s_rx_sample_source #(.DATA_WIDTH(W), .CHANNEL_SEL(0), .FIFO_DEPTH(4)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sclk(sclk), .i_lrclk(lrclk),
    .i_sdata(sdata), .i_ready(ready0), .i_clr_err(clr_err), .ov_dout(dout0),
    .o_left(left0), .o_dout_valid(valid0), .o_overflow(ovf0), .o_frame_err(ferr0));

  i2s_rx_sample_source #(.DATA_WIDTH(W), .CHANNEL_SEL(2), .FIFO_DEPTH(4)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_sclk(sclk), .i_lrclk(lrclk),
    .i_sdata(sdata), .i_ready(ready2), .i_clr_err(clr_err), .ov_dout(dout2),
    .o_left(left2), .o_dout_valid(valid2), .o_overflow(ovf2), .o_frame_err(ferr2));

  int vectors = 0;
  int miscompares = 0;

  logic [W:0] q0[$];
  logic [W:0] q2[$];
  int   mode0 = 1, mode2 = 1;   // 0 = hold low, 1 = hold high, 2 = random
  int   blocked[2];
  int   occ[2];
  logic exp_ovf[2];
  logic exp_ferr;
  logic prev_valid, prev_lr, pending_short, t4_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    ready0 = (mode0 == 2) ? 1'($urandom_range(0, 1)) : (mode0 == 1);
    ready2 = (mode2 == 2) ? 1'($urandom_range(0, 1)) : (mode2 == 1);
  end

  always @(negedge clk) begin
    if (rst_n && valid0 && ready0) begin
      if (q0.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL dut0_unexpected: got %0h expected none", {left0, dout0});
      end else check("dut0_word", {left0, dout0}, q0.pop_front());
    end
    if (rst_n && valid2 && ready2) begin
      if (q2.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL dut2_unexpected: got %0h expected none", {left2, dout2});
      end else check("dut2_word", {left2, dout2}, q2.pop_front());
    end
  end

  task automatic expect_word(input int d, input logic [W:0] v);
    if (blocked[d] != 0 && !(d == 0 && t4_pass)) begin
      if (occ[d] < 4) begin
        occ[d]++;
        if (d == 0) q0.push_back(v); else q2.push_back(v);
      end else exp_ovf[d] = 1'b1;
    end else begin
      if (d == 0) q0.push_back(v); else q2.push_back(v);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_ovf0"}, ovf0, exp_ovf[0]);
    check({tag, "_ovf2"}, ovf2, exp_ovf[1]);
    check({tag, "_ferr0"}, ferr0, exp_ferr);
    check({tag, "_ferr2"}, ferr2, exp_ferr);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dout0"}, {left0, valid0, ovf0, ferr0, dout0}, 0);
    check({tag, "_dout2"}, {left2, valid2, ovf2, ferr2, dout2}, 0);
  endtask

  // One SCLK period (8 i_clk): data/lrclk change while sclk is low, rise at a negedge.
  // hook 1: latency probe on dut0; hook 2: pop dut0 in exactly the push cycle.
  task automatic do_bit(input logic lr, input logic d, input int hook);
    lrclk = lr; sdata = d;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    if (hook == 0) repeat (4) @(negedge clk);
    else begin
      repeat (3) @(posedge clk);
      if (hook == 2) mode0 = 1;
      #1;
      if (hook == 1) check("latency_n2_valid", valid0, 0);
      @(posedge clk);
      if (hook == 2) mode0 = 0;
      #1;
      if (hook == 1) check("latency_n3_valid", valid0, 1);
      @(negedge clk);
    end
    sclk = 1'b0;
  endtask

  task automatic reset_mid();
    rst_n = 1'b0;
    q0.delete(); q2.delete();
    occ[0] = 0; occ[1] = 0;
    exp_ovf[0] = 0; exp_ovf[1] = 0; exp_ferr = 0;
    pending_short = 0; prev_valid = 0;
    repeat (3) @(negedge clk);
    check_zero("reset_mid");
    rst_n = 1'b1;
  endtask

  task automatic send_slot(input logic lr, input int len, input logic [W-1:0] word,
                           input int hook, input logic en_val, input int en_on_rise,
                           input int rst_after);
    logic captured, b;
    en = (en_on_rise > 0) ? 1'b0 : en_val;
    if (pending_short && en && prev_valid && lr != prev_lr) exp_ferr = 1'b1;
    captured = prev_valid && (lr != prev_lr) && en && (rst_after == 0);
    if (captured && len >= W + 1) begin
      if (!lr) expect_word(0, {1'b1, word});
      expect_word(1, {~lr, word});
    end
    pending_short = captured && (len < W + 1);
    for (int r = 1; r <= len; r++) begin
      if (en_on_rise == r) en = 1'b1;
      b = (r >= 2 && r <= W + 1) ? word[W + 1 - r] : 1'($urandom_range(0, 1));
      do_bit(lr, b, (r == W + 1) ? hook : 0);
      if (rst_after > 0 && r == rst_after + 1) reset_mid();
    end
    prev_valid = 1'b1;
    prev_lr = lr;
  endtask

  task automatic frame(input logic [W-1:0] l, input logic [W-1:0] r, input int len);
    send_slot(1'b0, len, l, 0, 1'b1, 0, 0);
    send_slot(1'b1, len, r, 0, 1'b1, 0, 0);
  endtask

  task automatic drain();
    int n = 0;
    mode0 = 1; mode2 = 1;
    blocked[0] = 0; blocked[1] = 0;
    while ((q0.size() != 0 || q2.size() != 0) && n < 200) begin
      @(negedge clk); n++;
    end
    repeat (4) @(negedge clk);
    check("drain_q0_empty", q0.size(), 0);
    check("drain_q2_empty", q2.size(), 0);
  endtask

  task automatic clear_err();
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    exp_ovf[0] = 0; exp_ovf[1] = 0; exp_ferr = 0;
    @(negedge clk);
    check_flags("after_clr");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; en = 0; sclk = 0; lrclk = 1; sdata = 0; clr_err = 0;
    blocked[0] = 0; blocked[1] = 0; occ[0] = 0; occ[1] = 0;
    exp_ovf[0] = 0; exp_ovf[1] = 0; exp_ferr = 0;
    prev_valid = 0; prev_lr = 1; pending_short = 0; t4_pass = 0;
    repeat (5) @(negedge clk);
    check_zero("in_reset");
    rst_n = 1;
    repeat (3) @(negedge clk);
    check_zero("after_reset");

    // preamble primes lrclk history; never captured
    send_slot(1'b1, 4, '0, 0, 1'b1, 0, 0);

    // T1: fixed words, left only on dut0, push latency probed on first word
    for (int i = 0; i < 3; i++) begin
      send_slot(1'b0, 32, 24'h123456, (i == 0) ? 1 : 0, 1'b1, 0, 0);
      send_slot(1'b1, 32, 24'hABCDEF, 0, 1'b1, 0, 0);
    end
    check_flags("t1");

    // T2: extreme values, pad bits random
    for (int i = 0; i < 3; i++) frame(24'h800000, 24'h7FFFFF, 32);

    // randomized words, slot lengths and consumer backpressure
    mode0 = 2; mode2 = 2;
    for (int i = 0; i < 12; i++)
      frame(W'($urandom), W'($urandom), $urandom_range(W + 1, 32));
    check_flags("random");

    // enable gating: a slot with en low, en rising mid-slot, then capture resumes
    send_slot(1'b0, 32, W'($urandom), 0, 1'b0, 0, 0);
    send_slot(1'b1, 32, W'($urandom), 0, 1'b1, 5, 0);
    send_slot(1'b0, 32, W'($urandom), 0, 1'b1, 0, 0);
    send_slot(1'b1, 32, W'($urandom), 0, 1'b1, 0, 0);
    drain();

    // T3: consumer stalled for 6 frames
    mode0 = 0; mode2 = 0; blocked[0] = 1; blocked[1] = 1;
    for (int i = 0; i < 6; i++) begin
      frame(W'($urandom), W'($urandom), 32);
      if (i == 3 || i == 4) check_flags("t3_mid");
    end
    check_flags("t3_end");
    drain();
    clear_err();

    // T4: dut0 full, push coincides with a pop
    mode0 = 0; blocked[0] = 1; occ[0] = 0; mode2 = 2;
    for (int i = 0; i < 4; i++) frame(W'($urandom), W'($urandom), 32);
    t4_pass = 1;
    send_slot(1'b0, 32, W'($urandom), 2, 1'b1, 0, 0);
    t4_pass = 0;
    send_slot(1'b1, 32, W'($urandom), 0, 1'b1, 0, 0);
    check_flags("t4");
    drain();

    // T5: short slot flags a frame error, next slot still captured
    mode0 = 2; mode2 = 2;
    send_slot(1'b0, 16, W'($urandom), 0, 1'b1, 0, 0);
    send_slot(1'b1, 32, W'($urandom), 0, 1'b1, 0, 0);
    send_slot(1'b0, 32, W'($urandom), 0, 1'b1, 0, 0);
    check_flags("t5");
    clear_err();

    // T6: reset 10 bits into a left slot
    send_slot(1'b1, 32, W'($urandom), 0, 1'b1, 0, 0);
    drain();
    send_slot(1'b0, 32, W'($urandom), 0, 1'b1, 0, 10);
    frame(W'($urandom), W'($urandom), 32);
    frame(W'($urandom), W'($urandom), 32);
    drain();
    check_flags("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
